i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting the command FIFO depth in entries (power of 2, at least 2).
REQ-002 The block SHALL have parameter START_TO, default 64, the maximum clk cycles to wait for m_busy to rise after launch.
REQ-003 The block SHALL have parameter DONE_TO, default 65535, the maximum clk cycles to wait for m_busy to fall after it rises.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept a command
- cmd_addr  in  7  target slave address
- cmd_rw  in  1  1 = read, 0 = write
- cmd_len  in  10  byte count; legal range is 1..10
- cmd_data  in  10x8  write payload; byte 0 goes first
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_status  out  2  00 = OK, 01 = ACK_ERR, 10 = TIMEOUT, 11 = BAD_LEN
- rsp_data  out  10x8  read data; all zero for writes and errors
- m_en  out  1  master start pulse
- m_slave_addr  out  7  to master
- m_read_write  out  1  to master
- m_no_of_bytes  out  10  to master
- m_data_in  out  10x8  to master
- m_data_out  in  10x8  from master
- m_busy  in  1  master busy
- m_ack_error  in  1  master NACK flag
- idle  out  1  high when the FSM is in IDLE and the FIFO is empty

Function
REQ-005 The FIFO SHALL push {addr, rw, len, data} on any cycle where cmd_valid and cmd_ready are both high.
REQ-006 cmd_ready SHALL equal !full, derived from the registered count.
REQ-007 A simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-008 The FSM SHALL have the states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and RESPOND.
REQ-009 IDLE SHALL pop the head entry into a holding register and go to LAUNCH when the FIFO is non-empty, m_busy is 0 and rsp_valid is 0.
REQ-010 In IDLE, if the popped entry has cmd_len = 0 or cmd_len > 10, the FSM SHALL skip launch, load status BAD_LEN and go to RESPOND.
REQ-011 The m_* outputs SHALL be driven from the holding register and SHALL stay stable from LAUNCH until leaving WAIT_DONE.
REQ-012 LAUNCH SHALL assert m_en for exactly one cycle and then go to WAIT_BUSY.
REQ-013 WAIT_BUSY SHALL go to WAIT_DONE when m_busy = 1.
REQ-014 WAIT_BUSY SHALL go to RESPOND with status TIMEOUT if m_busy is not seen within START_TO cycles.
REQ-015 WAIT_DONE SHALL OR m_ack_error into a sticky flag on every cycle.
REQ-016 WAIT_DONE SHALL leave on the first cycle m_busy = 0, using this priority for status:
- sticky flag or m_ack_error that cycle: ACK_ERR
- otherwise: OK
REQ-017 On that exit cycle, if the status is OK and cmd_rw = 1, the block SHALL capture m_data_out into rsp_data; otherwise rsp_data SHALL be zero.
REQ-018 WAIT_DONE SHALL exit with TIMEOUT after DONE_TO cycles with m_busy still 1.
REQ-019 If m_busy falls and the DONE_TO limit is reached in the same cycle, completion SHALL win: the status is OK or ACK_ERR, not TIMEOUT.
REQ-020 RESPOND SHALL set rsp_valid = 1 and hold rsp_status and rsp_data stable until the cycle where rsp_ready = 1.
REQ-021 On that handshake cycle, rsp_valid SHALL drop on the next edge and the FSM SHALL go to IDLE; one response SHALL be produced per command.
REQ-022 The timeout counter SHALL be 16 bits, SHALL clear on every state change and SHALL saturate rather than wrap.
REQ-023 m_busy high while in IDLE SHALL block launch; the command SHALL stay queued and none SHALL be lost.
REQ-024 The FIFO SHALL keep accepting commands during any FSM state.

Reset
REQ-025 On reset = 1 at a clk edge, the following SHALL hold on the next cycle:
- FSM in IDLE, FIFO empty, counters and sticky flag cleared
- m_en = 0, rsp_valid = 0, rsp_status = 00, rsp_data = 0
- all m_* outputs = 0, cmd_ready = 1, idle = 1
REQ-026 Reset asserted mid-transaction SHALL abort it with no response, discarding queued commands and any pending response.

Verification
REQ-027 Write: addr 0x54, len 3, data 0xA1/B2/C3; m_busy rises 2 cycles after m_en and is held 20 cycles with no ack_error -> one m_en pulse, m_no_of_bytes = 3, response OK with rsp_data = 0.
REQ-028 Read: addr 0x57, len 2; master returns 0x5A, 0x3C -> status OK, rsp_data bytes 0/1 = 0x5A/0x3C, all other bytes 0.
REQ-029 Error paths:
- m_ack_error pulses 1 cycle mid-busy -> ACK_ERR
- m_busy never rises -> TIMEOUT exactly START_TO cycles after WAIT_BUSY entry
- cmd_len 0 or 11 -> BAD_LEN with m_en never asserted
REQ-030 FIFO: push DEPTH+1 commands back-to-back with rsp_ready = 0 -> cmd_ready drops after DEPTH accepts (one held in the FSM allows DEPTH+1 total); all responses emerge in order once rsp_ready = 1.
REQ-031 Reset 5 cycles into WAIT_DONE with 2 commands queued -> all reset values next cycle, no rsp_valid, FIFO empty.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// I2C command sequencer: queues transfer commands and runs them one at a
// time on an external byte-oriented I2C master, returning one status each.
module i2c_cmd_sequencer #(
  parameter int DEPTH    = 4,
  parameter int START_TO = 64,
  parameter int DONE_TO  = 65535
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [6:0]      cmd_addr,
  input  logic            cmd_rw,
  input  logic [9:0]      cmd_len,
  input  logic [9:0][7:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [1:0]      rsp_status,
  output logic [9:0][7:0] rsp_data,
  output logic            m_en,
  output logic [6:0]      m_slave_addr,
  output logic            m_read_write,
  output logic [9:0]      m_no_of_bytes,
  output logic [9:0][7:0] m_data_in,
  input  logic [9:0][7:0] m_data_out,
  input  logic            m_busy,
  input  logic            m_ack_error,
  output logic            idle
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ACK_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BAD_LEN = 2'b11;

  localparam logic [15:0] START_LIM = 16'(START_TO - 1);
  localparam logic [15:0] DONE_LIM  = 16'(DONE_TO - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [6:0]      addr;
    logic            rw;
    logic [9:0]      len;
    logic [9:0][7:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESPOND
  } state_e;

  cmd_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            sticky_q, sticky_d;
  cmd_t            hold_q, hold_d;
  logic [1:0]      status_q, status_d;
  logic [9:0][7:0] rdata_q, rdata_d;

  logic full, empty, push, pop;
  cmd_t cmd_in, head;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_q];

  assign cmd_in.addr = cmd_addr;
  assign cmd_in.rw   = cmd_rw;
  assign cmd_in.len  = cmd_len;
  assign cmd_in.data = cmd_data;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= cmd_in;
    end
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    hold_d   = hold_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    sticky_d = sticky_q;
    unique case (state_q)
      S_IDLE: begin
        sticky_d = 1'b0;
        if (!empty && !m_busy && !rsp_valid) begin
          pop    = 1'b1;
          hold_d = head;
          if (head.len == 10'd0 || head.len > 10'd10) begin
            status_d = ST_BAD_LEN;
            rdata_d  = '0;
            state_d  = S_RESPOND;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (m_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q >= START_LIM) begin
          status_d = ST_TIMEOUT;
          rdata_d  = '0;
          state_d  = S_RESPOND;
        end
      end
      S_WAIT_DONE: begin
        sticky_d = sticky_q | m_ack_error;
        // completion is checked first so a late fall beats the timeout
        if (!m_busy) begin
          status_d = sticky_d ? ST_ACK_ERR : ST_OK;
          rdata_d  = (!sticky_d && hold_q.rw) ? m_data_out : '0;
          state_d  = S_RESPOND;
        end else if (cnt_q >= DONE_LIM) begin
          status_d = ST_TIMEOUT;
          rdata_d  = '0;
          state_d  = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      hold_q   <= '0;
      status_q <= ST_OK;
      rdata_q  <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      hold_q   <= hold_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rsp_valid     = (state_q == S_RESPOND);
  assign rsp_status    = status_q;
  assign rsp_data      = rdata_q;
  assign m_en          = (state_q == S_LAUNCH);
  assign m_slave_addr  = hold_q.addr;
  assign m_read_write  = hold_q.rw;
  assign m_no_of_bytes = hold_q.len;
  assign m_data_in     = hold_q.data;
  assign idle          = (state_q == S_IDLE) && empty;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a small behavioural I2C master.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH    = 4;
  localparam int START_TO = 16;
  localparam int DONE_TO  = 40;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [6:0]      cmd_addr;
  logic            cmd_rw;
  logic [9:0]      cmd_len;
  logic [9:0][7:0] cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_status;
  logic [9:0][7:0] rsp_data;
  logic            m_en;
  logic [6:0]      m_slave_addr;
  logic            m_read_write;
  logic [9:0]      m_no_of_bytes;
  logic [9:0][7:0] m_data_in;
  logic [9:0][7:0] m_data_out;
  logic            m_busy;
  logic            m_ack_error;
  logic            idle;

  i2c_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .START_TO(START_TO),
    .DONE_TO (DONE_TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_rw       (cmd_rw),
    .cmd_len      (cmd_len),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_status   (rsp_status),
    .rsp_data     (rsp_data),
    .m_en         (m_en),
    .m_slave_addr (m_slave_addr),
    .m_read_write (m_read_write),
    .m_no_of_bytes(m_no_of_bytes),
    .m_data_in    (m_data_in),
    .m_data_out   (m_data_out),
    .m_busy       (m_busy),
    .m_ack_error  (m_ack_error),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // master model knobs and captures
  logic            mdl_on   = 1'b1;
  logic            mdl_uadr = 1'b0;
  int              mdl_dly  = 2;
  int              mdl_hold = 20;
  int              mdl_ack  = -1;
  logic [9:0][7:0] mdl_rd   = '0;
  int              en_cnt   = 0;
  logic [6:0]      cap_addr;
  logic            cap_rw;
  logic [9:0]      cap_nob;
  logic [9:0][7:0] cap_din;
  logic            stab_ok;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int h;
    int a;
    m_busy      = 1'b0;
    m_ack_error = 1'b0;
    m_data_out  = '0;
    stab_ok     = 1'b0;
    forever begin
      @(negedge clk);
      if (m_en) begin
        en_cnt++;
        cap_addr = m_slave_addr;
        cap_rw   = m_read_write;
        cap_nob  = m_no_of_bytes;
        cap_din  = m_data_in;
        if (mdl_on) begin
          h = mdl_hold;
          a = mdl_ack;
          repeat (mdl_dly) @(negedge clk);
          m_busy = 1'b1;
          m_data_out = mdl_uadr ? {72'h0, 1'b0, m_slave_addr} : mdl_rd;
          for (int i = 0; i < h; i++) begin
            m_ack_error = (i == a);
            @(negedge clk);
          end
          m_ack_error = 1'b0;
          m_busy = 1'b0;
          stab_ok = (m_slave_addr == cap_addr) && (m_read_write == cap_rw)
                 && (m_no_of_bytes == cap_nob) && (m_data_in == cap_din);
        end
      end
    end
  end

  task automatic push(input logic [6:0] a, input logic rw,
                      input logic [9:0] len, input logic [9:0][7:0] d);
    int n;
    n = 0;
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_len   = len;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("push_rdy", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [1:0] st, output logic [79:0] d);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", rsp_valid, 1'b1);
    st = rsp_status;
    d  = rsp_data;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]      st;
    logic [79:0]     d;
    logic [9:0][7:0] wd;
    logic [9:0][7:0] junk;
    int              e0;
    int              n;
    int              acc;
    logic            r;
    logic            saw_en;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_rw    = 1'b0;
    cmd_len   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    junk      = 80'hDEAD_BEEF_CAFE_F00D_1234;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_status", rsp_status, 2'b00);
    chk("rst_rdata", rsp_data, 80'h0);
    chk("rst_m_out", {m_en, m_slave_addr, m_read_write, m_no_of_bytes,
                      m_data_in}, 99'h0);
    reset = 1'b0;
    @(negedge clk);

    // plain write
    mdl_dly = 2; mdl_hold = 20; mdl_ack = -1; mdl_rd = junk;
    wd = '0; wd[0] = 8'hA1; wd[1] = 8'hB2; wd[2] = 8'hC3;
    e0 = en_cnt;
    push(7'h54, 1'b0, 10'd3, wd);
    get_rsp(st, d);
    chk("wr_en_pulses", en_cnt - e0, 1);
    chk("wr_nob", cap_nob, 10'd3);
    chk("wr_addr", cap_addr, 7'h54);
    chk("wr_rw", cap_rw, 1'b0);
    chk("wr_din", cap_din, wd);
    chk("wr_stable", stab_ok, 1'b1);
    chk("wr_status", st, 2'b00);
    chk("wr_rdata", d, 80'h0);

    // read returning two bytes
    mdl_rd = '0; mdl_rd[0] = 8'h5A; mdl_rd[1] = 8'h3C;
    push(7'h57, 1'b1, 10'd2, '0);
    get_rsp(st, d);
    chk("rd_status", st, 2'b00);
    chk("rd_data", d, 80'h3C5A);
    chk("rd_rw", cap_rw, 1'b1);

    // one-cycle NACK mid-busy on a read
    mdl_ack = 5; mdl_rd = junk;
    push(7'h33, 1'b1, 10'd1, '0);
    get_rsp(st, d);
    chk("ack_status", st, 2'b01);
    chk("ack_rdata", d, 80'h0);
    mdl_ack = -1;

    // master never goes busy
    mdl_on = 1'b0;
    push(7'h11, 1'b0, 10'd1, wd);
    n = 0;
    while (!m_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sto_launch", m_en, 1'b1);
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("sto_cycles", n, START_TO);
    get_rsp(st, d);
    chk("sto_status", st, 2'b10);
    mdl_on = 1'b1;

    // illegal lengths never reach the master
    e0 = en_cnt;
    push(7'h20, 1'b0, 10'd0, wd);
    get_rsp(st, d);
    chk("len0_status", st, 2'b11);
    chk("len0_rdata", d, 80'h0);
    push(7'h21, 1'b1, 10'd11, wd);
    get_rsp(st, d);
    chk("len11_status", st, 2'b11);
    chk("badlen_no_en", en_cnt - e0, 0);

    // busy falls on the last allowed cycle, then one cycle too late
    mdl_hold = DONE_TO;
    push(7'h40, 1'b0, 10'd1, wd);
    get_rsp(st, d);
    chk("dto_edge_ok", st, 2'b00);
    mdl_hold = DONE_TO + 1;
    push(7'h41, 1'b0, 10'd1, wd);
    get_rsp(st, d);
    chk("dto_status", st, 2'b10);

    // master still busy after a timeout must hold off the next command
    mdl_hold = DONE_TO + 20;
    e0 = en_cnt;
    push(7'h42, 1'b0, 10'd1, wd);
    get_rsp(st, d);
    chk("blk_to_status", st, 2'b10);
    mdl_hold = 5;
    push(7'h43, 1'b0, 10'd2, wd);
    saw_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_en = saw_en | m_en;
    end
    chk("blk_busy_held", m_busy, 1'b1);
    chk("blk_no_launch", saw_en, 1'b0);
    chk("blk_not_idle", idle, 1'b0);
    get_rsp(st, d);
    chk("blk_status", st, 2'b00);
    chk("blk_nob", cap_nob, 10'd2);
    chk("blk_en_total", en_cnt - e0, 2);

    // fill the queue with responses held back
    mdl_uadr = 1'b1; mdl_hold = 3;
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      cmd_addr  = 7'(7'h10 + acc);
      cmd_rw    = 1'b1;
      cmd_len   = 10'd1;
      cmd_data  = '0;
      cmd_valid = 1'b1;
      r = cmd_ready;
      @(negedge clk);
      if (r) acc++;
    end
    cmd_valid = 1'b0;
    chk("fifo_accepts", acc, DEPTH + 1);
    chk("fifo_full", cmd_ready, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      get_rsp(st, d);
      chk("fifo_order", d, 80'(8'h10 + i));
      chk("fifo_status", st, 2'b00);
    end

    // reset in the middle of a transfer with two commands queued
    mdl_uadr = 1'b0; mdl_hold = 60;
    push(7'h22, 1'b0, 10'd2, wd);
    n = 0;
    while (!m_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    push(7'h23, 1'b0, 10'd1, wd);
    push(7'h24, 1'b0, 10'd1, wd);
    @(negedge clk);
    chk("mid_not_idle", idle, 1'b0);
    chk("mid_rdata_old", rsp_data, 80'h14);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_rsp_valid", rsp_valid, 1'b0);
    chk("mrst_idle", idle, 1'b1);
    chk("mrst_cmd_ready", cmd_ready, 1'b1);
    chk("mrst_rdata", rsp_data, 80'h0);
    chk("mrst_m_out", {m_en, m_slave_addr, m_read_write, m_no_of_bytes,
                       m_data_in}, 99'h0);
    reset = 1'b0;
    e0 = en_cnt;
    n = 0;
    while (m_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("mrst_no_launch", en_cnt - e0, 0);
    chk("mrst_no_rsp", rsp_valid, 1'b0);
    chk("mrst_idle_after", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
